// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES byte-wide controller.
//   state_t          controller FSM states
//   NBYTES, CNT_W    bytes per block and byte-counter width
//   BLK_W            AES block width in bits
//   tmo_width()      counter width needed to count up to TIMEOUT_CYC-1
package aes_ctrl_pkg;

  localparam int unsigned NBYTES          = 16;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned BLK_W           = 128;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BUSY,
    OUT
  } state_t;

  function automatic int unsigned tmo_width(input int unsigned cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

  localparam int unsigned TMO_W_DEF = tmo_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/aes_byte_shreg.sv
// aes_byte_shreg: block-wide register with byte shift in/out.
//   clk, rst_n   clock, asynchronous active-low reset (clears q)
//   ld/ld_data   parallel load (highest priority)
//   shin/shin_byte  shift left one byte, new byte enters at the LSB end
//   shout        shift left one byte, zero enters at the LSB end
//   q            register contents; q[W-1:W-8] is the next byte out
module aes_byte_shreg
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned W = BLK_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_data,
  input  logic         shin,
  input  logic [7:0]   shin_byte,
  input  logic         shout,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_data;
    end else if (shin) begin
      q <= {q[W-9:0], shin_byte};
    end else if (shout) begin
      q <= {q[W-9:0], 8'h00};
    end
  end

endmodule

// File: rtl/aes_byte_ctrl.sv
// aes_byte_ctrl: byte-wide host controller sequencing a 128-bit AES core.
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  byte input stream, MSB first
//   in_is_key                  block type, sampled with the first byte of a block
//   core_ld                    one-cycle start pulse to the core
//   core_key, core_text_in     held key and text registers
//   core_done, core_text_out   core completion pulse and result
//   out_valid/out_ready/out_data  byte output stream, MSB first, backpressured
//   busy                       high in START, BUSY and OUT
//   err                        one-cycle core timeout pulse
// Optional feature macro: AES_CTRL_TIMEOUT_EN (core timeout of TIMEOUT_CYC
// cycles from core_ld; without it BUSY waits forever and err is 0).
module aes_byte_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NBYTES      = aes_ctrl_pkg::NBYTES,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_is_key,
  output logic             core_ld,
  output logic [BLK_W-1:0] core_key,
  output logic [BLK_W-1:0] core_text_in,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_text_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             is_key, is_key_nxt;
  logic             run_q;
  logic             in_fire;
  logic             key_shin, text_shin;
  logic             res_ld, res_shout;
  logic             tmo_hit;
  logic [BLK_W-1:0] res_q;

  // run_q keeps in_ready low while reset is asserted even though the
  // reset state is IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_key <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      is_key <= is_key_nxt;
      run_q  <= 1'b1;
    end
  end

  assign in_ready  = run_q && ((state == IDLE) || (state == LOAD));
  assign in_fire   = in_valid && in_ready;
  assign core_ld   = (state == START);
  assign busy      = (state == START) || (state == BUSY) || (state == OUT);
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? res_q[BLK_W-1 -: 8] : '0;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = tmo_width(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tcnt;

  // tcnt is 0 in the first BUSY cycle, so the last allowed cycle is
  // TIMEOUT_CYC cycles after core_ld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state == START) begin
      tcnt <= '0;
    end else if (state == BUSY) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tmo_hit = (state == BUSY) && !core_done && (tcnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign err = tmo_hit;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    is_key_nxt = is_key;
    key_shin   = 1'b0;
    text_shin  = 1'b0;
    res_ld     = 1'b0;
    res_shout  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_fire) begin
          is_key_nxt = in_is_key;
          key_shin   = in_is_key;
          text_shin  = !in_is_key;
          cnt_nxt    = CNT_W'(1);
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        if (in_fire) begin
          key_shin  = is_key;
          text_shin = !is_key;
          cnt_nxt   = cnt + 1'b1;
          if (cnt == LAST_BYTE) begin
            state_nxt = is_key ? IDLE : START;
          end
        end
      end
      START: begin
        state_nxt = BUSY;
      end
      BUSY: begin
        if (core_done) begin
          res_ld    = 1'b1;
          state_nxt = OUT;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          res_shout = 1'b1;
          cnt_nxt   = cnt + 1'b1;
          if (cnt == LAST_BYTE) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  aes_byte_shreg #(.W(BLK_W)) u_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld        (1'b0),
    .ld_data   ('0),
    .shin      (key_shin),
    .shin_byte (in_data),
    .shout     (1'b0),
    .q         (core_key)
  );

  aes_byte_shreg #(.W(BLK_W)) u_text (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld        (1'b0),
    .ld_data   ('0),
    .shin      (text_shin),
    .shin_byte (in_data),
    .shout     (1'b0),
    .q         (core_text_in)
  );

  aes_byte_shreg #(.W(BLK_W)) u_res (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld        (res_ld),
    .ld_data   (core_text_out),
    .shin      (1'b0),
    .shin_byte ('0),
    .shout     (res_shout),
    .q         (res_q)
  );

endmodule

// File: tb/tb_aes_byte_ctrl.sv
// tb_aes_byte_ctrl: directed self-checking bench for aes_byte_ctrl with a
// fixed-latency AES core model (result returned 10 cycles after core_ld).
module tb_aes_byte_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_is_key;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text_in;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         busy;
  logic         err;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_RES  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] REV_TEXT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] RES_B     = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] RES_C     = 128'hdeadbeef00112233cafef00d44556677;

  always #5 clk = ~clk;

  aes_byte_ctrl #(.NBYTES(16), .TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_is_key     (in_is_key),
    .core_ld       (core_ld),
    .core_key      (core_key),
    .core_text_in  (core_text_in),
    .core_done     (core_done),
    .core_text_out (core_text_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .err           (err)
  );

  // Core model: done pulse 10 cycles after the core_ld cycle.
  logic         core_en = 1'b1;
  logic         model_done = 1'b0;
  logic         spur_done = 1'b0;
  logic [127:0] core_res = '0;
  int           lat = 0;
  int           ld_cnt = 0;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (core_ld && core_en) begin
      lat <= 9;
    end else if (lat == 1) begin
      lat        <= 0;
      model_done <= 1'b1;
    end else if (lat > 1) begin
      lat <= lat - 1;
    end
    if (core_ld) ld_cnt <= ld_cnt + 1;
  end

  assign core_done     = model_done | spur_done;
  assign core_text_out = core_res;

  // Enter and leave at a negedge; the handshake happens on the posedge between.
  task automatic send_byte(input logic [7:0] b, input logic k, input bit gaps);
    int unsigned w;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid  = 1'b1;
    in_data   = b;
    in_is_key = k;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_byte_wait: in_ready=%b after %0d cycles, required 1", in_ready, w);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_is_key = 1'b0;
    in_data   = '0;
  endtask

  // Bytes after the first carry the opposite in_is_key, which must be ignored.
  task automatic send_bytes(input logic [127:0] blk, input logic key, input bit gaps,
                            input int unsigned first, input int unsigned last);
    for (int unsigned i = first; i <= last; i++) begin
      send_byte(blk[127 - 8*i -: 8], (i == 0) ? key : ~key, gaps);
    end
  endtask

  task automatic recv_bytes(input int unsigned n, input bit toggle,
                            output logic [127:0] got, output int unsigned k,
                            output int unsigned stalls);
    logic        held;
    logic [7:0]  hv;
    int unsigned cyc;
    got = '0; k = 0; stalls = 0; held = 1'b0; hv = '0; cyc = 0;
    while (k < n && cyc < 400) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      if (held && (out_valid !== 1'b1 || out_data !== hv)) stalls++;
      held = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          got = {got[119:0], out_data};
          k++;
        end else begin
          held = 1'b1;
          hv   = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_is_key = 1'b0; out_ready = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, core_ld, out_valid, busy, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {in_ready,core_ld,out_valid,busy,err}=%b, required 00000",
               {in_ready, core_ld, out_valid, busy, err});
    end
    tests_run++;
    if (core_key !== '0 || core_text_in !== '0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: key=%h text=%h out_data=%h, required all 0",
               core_key, core_text_in, out_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_fips;
    logic [127:0] got;
    int unsigned  k, st;
    int           ld0;
    core_res = FIPS_RES;
    send_bytes(FIPS_KEY, 1'b1, 1'b0, 0, 15);
    tests_run++;
    if (core_key !== FIPS_KEY || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_key: key=%h busy=%b in_ready=%b, required %h 0 1",
               core_key, busy, in_ready, FIPS_KEY);
    end
    ld0 = ld_cnt;
    send_bytes(FIPS_TEXT, 1'b0, 1'b0, 0, 15);
    tests_run++;
    if (core_ld !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fips_start: core_ld=%b busy=%b in_ready=%b, required 1 1 0",
               core_ld, busy, in_ready);
    end
    tests_run++;
    if (core_text_in !== FIPS_TEXT) begin
      tests_failed++;
      $display("FAIL fips_text: core_text_in=%h, required %h", core_text_in, FIPS_TEXT);
    end
    recv_bytes(16, 1'b0, got, k, st);
    tests_run++;
    if (got !== FIPS_RES || k != 16) begin
      tests_failed++;
      $display("FAIL fips_out: got=%h (%0d bytes), required %h (16 bytes)", got, k, FIPS_RES);
    end
    tests_run++;
    if (ld_cnt - ld0 != 1) begin
      tests_failed++;
      $display("FAIL fips_ld_count: core_ld pulses=%0d, required 1", ld_cnt - ld0);
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL fips_done: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] got;
    int unsigned  k, st;
    core_res = FIPS_RES;
    send_bytes(FIPS_TEXT, 1'b0, 1'b1, 0, 15);
    tests_run++;
    if (core_text_in !== FIPS_TEXT || core_key !== FIPS_KEY) begin
      tests_failed++;
      $display("FAIL bp_regs: text=%h key=%h, required %h %h",
               core_text_in, core_key, FIPS_TEXT, FIPS_KEY);
    end
    recv_bytes(16, 1'b1, got, k, st);
    tests_run++;
    if (got !== FIPS_RES || k != 16) begin
      tests_failed++;
      $display("FAIL bp_out: got=%h (%0d bytes), required %h (16 bytes)", got, k, FIPS_RES);
    end
    tests_run++;
    if (st != 0) begin
      tests_failed++;
      $display("FAIL bp_stall_stable: %0d unstable stall cycles, required 0", st);
    end
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_done: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_key_reuse;
    logic [127:0] got;
    int unsigned  k, st;
    int           ld0;
    core_res = RES_B;
    ld0 = ld_cnt;
    send_bytes(REV_TEXT, 1'b0, 1'b0, 0, 15);
    tests_run++;
    if (core_ld !== 1'b1 || core_key !== FIPS_KEY || core_text_in !== REV_TEXT) begin
      tests_failed++;
      $display("FAIL reuse_regs: core_ld=%b key=%h text=%h, required 1 %h %h",
               core_ld, core_key, core_text_in, FIPS_KEY, REV_TEXT);
    end
    recv_bytes(16, 1'b0, got, k, st);
    tests_run++;
    if (got !== RES_B || k != 16 || ld_cnt - ld0 != 1) begin
      tests_failed++;
      $display("FAIL reuse_out: got=%h (%0d bytes, %0d ld), required %h (16 bytes, 1 ld)",
               got, k, ld_cnt - ld0, RES_B);
    end
  endtask

  task automatic test_spurious;
    logic [127:0] got;
    int unsigned  k, st;
    core_res = RES_C;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL spur_idle: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               out_valid, busy, in_ready);
    end
    send_bytes(FIPS_TEXT, 1'b0, 1'b0, 0, 4);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL spur_load: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               out_valid, busy, in_ready);
    end
    send_bytes(FIPS_TEXT, 1'b0, 1'b0, 5, 15);
    tests_run++;
    if (core_ld !== 1'b1 || core_text_in !== FIPS_TEXT) begin
      tests_failed++;
      $display("FAIL spur_block: core_ld=%b text=%h, required 1 %h", core_ld, core_text_in, FIPS_TEXT);
    end
    recv_bytes(16, 1'b0, got, k, st);
    tests_run++;
    if (got !== RES_C || k != 16) begin
      tests_failed++;
      $display("FAIL spur_out: got=%h (%0d bytes), required %h (16 bytes)", got, k, RES_C);
    end
  endtask

  task automatic test_timeout;
    int unsigned bad;
    core_en = 1'b0;
    send_bytes(FIPS_TEXT, 1'b0, 1'b0, 0, 15);
    tests_run++;
    if (core_ld !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_start: core_ld=%b, required 1", core_ld);
    end
`ifdef AES_CTRL_TIMEOUT_EN
    bad = 0;
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (err !== (c == 8)) bad++;
      if (out_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL tmo_err_timing: %0d wrong cycles, required err only at cycle 8 and no out_valid", bad);
    end
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_idle: in_ready=%b err=%b busy=%b out_valid=%b, required 1 0 0 0",
               in_ready, err, busy, out_valid);
    end
`else
    bad = 0;
    for (int unsigned c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (err !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL no_tmo_wait: %0d cycles with err!=0, busy!=1 or out_valid!=0, required 0", bad);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    core_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [127:0] got;
    int unsigned  k, st;
    core_res = FIPS_RES;
    send_bytes(FIPS_TEXT, 1'b0, 1'b0, 0, 15);
    recv_bytes(5, 1'b0, got, k, st);
    tests_run++;
    if (got[39:0] !== 40'h69c4e0d86a || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_partial: got=%h out_valid=%b, required 69c4e0d86a 1", got[39:0], out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, core_ld, out_valid, busy, err} !== 5'b0 || out_data !== '0 ||
        core_key !== '0 || core_text_in !== '0) begin
      tests_failed++;
      $display("FAIL rmid_reset: ctrl=%b out_data=%h key=%h text=%h, required all 0",
               {in_ready, core_ld, out_valid, busy, err}, out_data, core_key, core_text_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_res = RES_B;
    send_bytes(REV_TEXT, 1'b0, 1'b0, 0, 15);
    tests_run++;
    if (core_ld !== 1'b1 || core_key !== '0 || core_text_in !== REV_TEXT) begin
      tests_failed++;
      $display("FAIL rmid_block: core_ld=%b key=%h text=%h, required 1 0 %h",
               core_ld, core_key, core_text_in, REV_TEXT);
    end
    recv_bytes(16, 1'b0, got, k, st);
    tests_run++;
    if (got !== RES_B || k != 16) begin
      tests_failed++;
      $display("FAIL rmid_out: got=%h (%0d bytes), required %h (16 bytes)", got, k, RES_B);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_key_reuse();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
